// File: rtl/mem_copy_dma.sv
// Byte-wise block copy engine that drives the shared data-memory port while busy.
// Optional running checksum of copied bytes on output soma when CHECKSUM_EN is defined.
module mem_copy_dma #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              memRead,
    output logic              memWrite,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] escreveDado,
    input  logic [DATA_W-1:0] leDado
`ifdef CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] soma
`endif
);

    typedef enum logic [1:0] {IDLE, LER, ESCREVER, FIM} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src_r, dst_r, len_r, i_r;
    logic [ADDR_W-1:0] i_inc;
    logic [DATA_W-1:0] buf_r;
    logic              accept;

    function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] a,
                                                   input logic [ADDR_W-1:0] b);
        return a + b;
    endfunction

    assign i_inc = i_r + ADDR_W'(1);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (len == '0) ? FIM : LER;
                end
            end
            LER:      state_nxt = ESCREVER;
            ESCREVER: state_nxt = (i_inc == len_r) ? FIM : LER;
            FIM:      state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Outputs decode registered state only; start/src/dst/len/leDado never reach them.
    always_comb begin
        busy        = 1'b0;
        done        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        endereco    = '0;
        escreveDado = '0;
        unique case (state)
            LER: begin
                busy     = 1'b1;
                memRead  = 1'b1;
                endereco = addr_add(src_r, i_r);
            end
            ESCREVER: begin
                busy        = 1'b1;
                memWrite    = 1'b1;
                endereco    = addr_add(dst_r, i_r);
                escreveDado = buf_r;
            end
            FIM:     done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            src_r <= '0;
            dst_r <= '0;
            len_r <= '0;
            i_r   <= '0;
            buf_r <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                src_r <= src;
                dst_r <= dst;
                len_r <= len;
                i_r   <= '0;
            end
            if (state == LER) begin
                buf_r <= leDado;
            end
            if (state == ESCREVER) begin
                i_r <= i_inc;
            end
        end
    end

`ifdef CHECKSUM_EN
    function automatic logic [DATA_W-1:0] sum_wrap(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return a + b;
    endfunction

    // Sum wraps modulo 2**DATA_W and holds after FIM until the next accepted start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            soma <= '0;
        end else if (accept) begin
            soma <= '0;
        end else if (state == ESCREVER) begin
            soma <= sum_wrap(soma, buf_r);
        end
    end
`endif

endmodule
